ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xF4 enable-reporting,
//  0xFF reset) to the mouse via open-drain PS/2 clock/data, complementing the receive path

---
 rtl/ps2_host_tx_if.sv | 21 ++
 rtl/ps2_host_tx.sv | 160 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command/status handshake plus PS/2 pad levels and open-drain enables
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;
  logic [1:0] tx_err_code;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  modport master (
    output tx_data, tx_start, ps2_clk_in, ps2_data_in,
    input  tx_busy, tx_done, tx_err, tx_err_code, ps2_clk_oe, ps2_data_oe
  );
  modport slave (
    input  tx_data, tx_start, ps2_clk_in, ps2_data_in,
    output tx_busy, tx_done, tx_err, tx_err_code, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command byte transmitter with glitch filtering and watchdogs
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ      = 65_000_000,
  parameter int INHIBIT_US       = 100,
  parameter int RTS_US           = 1,
  parameter int START_TIMEOUT_US = 15000,
  parameter int BIT_TIMEOUT_US   = 2000,
  parameter int FILTER_LEN       = 8
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave bus
);
  localparam int US          = CLK_FREQ_HZ / 1_000_000;
  localparam int INHIBIT_CYC = INHIBIT_US * US;
  localparam int RTS_CYC     = RTS_US * US;
  localparam int START_CYC   = START_TIMEOUT_US * US;
  localparam int BIT_CYC     = BIT_TIMEOUT_US * US;
  localparam int M1          = INHIBIT_CYC > RTS_CYC ? INHIBIT_CYC : RTS_CYC;
  localparam int M2          = START_CYC > BIT_CYC ? START_CYC : BIT_CYC;
  localparam int CW          = $clog2((M1 > M2 ? M1 : M2) + 1);
  localparam int FW          = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE, DONE, ERR} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [9:0]         shreg_q, shreg_d;
  logic [3:0]         bitcnt_q, bitcnt_d;
  logic               clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0]         code_q, code_d;
  logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d;
  logic [1:0][FW-1:0] fcnt_q, fcnt_d;
  logic [1:0]         flip;
  logic [1:0]         ecode;
  logic               fall, expire, to_err;

  // bit 0 tracks the clock pad, bit 1 the data pad
  always_comb begin
    sync1_d = {bus.ps2_data_in, bus.ps2_clk_in};
    sync2_d = sync1_q;
    flip    = '0;
    filt_d  = filt_q;
    fcnt_d  = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      flip[i]   = sync2_q[i] != filt_q[i] && fcnt_q[i] == FW'(FILTER_LEN - 1);
      filt_d[i] = flip[i] ? sync2_q[i] : filt_q[i];
      fcnt_d[i] = (sync2_q[i] == filt_q[i] || flip[i]) ? '0 : fcnt_q[i] + 1'b1;
    end
    fall = filt_q[0] & flip[0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    expire    = cnt_q == '0;
    to_err    = 1'b0;
    ecode     = bitcnt_q == '0 ? 2'b01 : 2'b10;
    case (state_q)
      IDLE: if (bus.tx_start) begin
        state_d  = INHIBIT;
        busy_d   = 1'b1;
        clk_oe_d = 1'b1;
        cnt_d    = CW'(INHIBIT_CYC - 1);
        shreg_d  = {1'b1, ~^bus.tx_data, bus.tx_data};
        bitcnt_d = '0;
      end
      INHIBIT: if (expire) begin
        state_d   = RTS;
        data_oe_d = 1'b1;
        cnt_d     = CW'(RTS_CYC - 1);
      end else cnt_d = cnt_q - 1'b1;
      RTS: if (expire) begin
        state_d  = SHIFT;
        clk_oe_d = 1'b0;
        cnt_d    = CW'(START_CYC - 1);
      end else cnt_d = cnt_q - 1'b1;
      SHIFT: if (fall) begin
        data_oe_d = ~shreg_q[0];
        shreg_d   = shreg_q >> 1;
        bitcnt_d  = bitcnt_q + 1'b1;
        cnt_d     = CW'(BIT_CYC - 1);
        state_d   = bitcnt_q == 4'd9 ? ACK : SHIFT;
      end else if (expire) to_err = 1'b1;
      else cnt_d = cnt_q - 1'b1;
      ACK: if (fall) begin
        to_err  = filt_q[1];
        ecode   = 2'b11;
        state_d = WAIT_IDLE;
        cnt_d   = CW'(BIT_CYC - 1);
      end else if (expire) to_err = 1'b1;
      else cnt_d = cnt_q - 1'b1;
      WAIT_IDLE: if (&filt_q) begin
        state_d = DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end else if (expire) to_err = 1'b1;
      else cnt_d = cnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
    if (to_err) begin
      state_d   = ERR;
      err_d     = 1'b1;
      code_d    = ecode;
      busy_d    = 1'b0;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'b00;
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      filt_q    <= 2'b11;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      code_q    <= code_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign bus.tx_busy     = busy_q;
  assign bus.tx_done     = done_q;
  assign bus.tx_err      = err_q;
  assign bus.tx_err_code = code_q;
  assign bus.ps2_clk_oe  = clk_oe_q;
  assign bus.ps2_data_oe = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: device-side PS/2 BFM driving the host transmitter; frames checked against a parity model
module tb_ps2_host_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk = 1'b1, dev_data = 1'b1, glitch = 1'b0;
  int   checks = 0, errors = 0;
  int   done_cnt = 0, err_cnt = 0;
  logic done_busy, err_busy;
  logic [1:0] done_oe, err_oe, err_code;

  ps2_host_tx_if bus ();
  ps2_host_tx #(.CLK_FREQ_HZ(1_000_000), .FILTER_LEN(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  // open-drain pads: low if either side pulls
  assign bus.ps2_clk_in  = ~bus.ps2_clk_oe & dev_clk & ~glitch;
  assign bus.ps2_data_in = ~bus.ps2_data_oe & dev_data;

  always @(negedge clk) begin
    if (bus.tx_done) begin
      done_cnt++;
      done_busy = bus.tx_busy;
      done_oe   = {bus.ps2_clk_oe, bus.ps2_data_oe};
    end
    if (bus.tx_err) begin
      err_cnt++;
      err_busy = bus.tx_busy;
      err_oe   = {bus.ps2_clk_oe, bus.ps2_data_oe};
      err_code = bus.tx_err_code;
    end
  end

  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic p;
    p = ($countones(b) % 2) == 0;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    bus.tx_data  = b;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (bus.tx_busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (bus.tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_wait: busy=%b after %0d cycles, required 0", name, bus.tx_busy, t);
    end
    repeat (5) @(negedge clk);
  endtask

  // device side: waits for request-to-send, clocks n_edges, samples on clock high, optional ACK
  task automatic run_frame(input int n_edges, input logic ack, input int inject_at, input int glitch_at,
                           output logic [10:0] bits);
    int t = 0;
    bits = 'x;
    while (!(bus.tx_busy && !bus.ps2_clk_oe && bus.ps2_data_oe) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 1000) begin
      errors++;
      $display("FAIL rts_wait: no request-to-send within %0d cycles, required one", t);
      return;
    end
    repeat (20) @(negedge clk);
    bits[0] = bus.ps2_data_in;
    for (int k = 1; k <= n_edges && k <= 10; k++) begin
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      if (k == inject_at) begin
        bus.tx_data  = 8'h55;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        repeat (9) @(negedge clk);
      end else repeat (10) @(negedge clk);
      if (k == glitch_at) begin
        glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
      end
      bits[k] = bus.ps2_data_in;
      repeat (10) @(negedge clk);
    end
    if (n_edges > 10) begin
      dev_data = ack;
      repeat (10) @(negedge clk);
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      repeat (20) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic send_and_check(input logic [7:0] b, input string name, input int inject_at, input int glitch_at);
    logic [10:0] got;
    int d0 = done_cnt, e0 = err_cnt;
    start_tx(b);
    run_frame(11, 1'b0, inject_at, glitch_at, got);
    wait_idle(name);
    checks++;
    if (got !== model_frame(b)) begin
      errors++;
      $display("FAIL %s frame: sampled %b, required %b", name, got, model_frame(b));
    end
    checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL %s pulses: done=%0d err=%0d, required done=1 err=0", name, done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.tx_busy, bus.tx_done, bus.tx_err, bus.tx_err_code, bus.ps2_clk_oe, bus.ps2_data_oe} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: busy/done/err/code/clk_oe/data_oe=%b, required 0000000",
               {bus.tx_busy, bus.tx_done, bus.tx_err, bus.tx_err_code, bus.ps2_clk_oe, bus.ps2_data_oe});
    end
  endtask

  task automatic test_send_f4();
    logic [10:0] got;
    int n_inh = 0, n_rts = 0, d0 = done_cnt;
    start_tx(8'hF4);
    checks++;
    if (bus.tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL f4_busy: busy=%b after accept, required 1", bus.tx_busy);
    end
    while (bus.ps2_clk_oe && !bus.ps2_data_oe && n_inh < 1000) begin
      n_inh++;
      @(negedge clk);
    end
    while (bus.ps2_clk_oe && bus.ps2_data_oe && n_rts < 1000) begin
      n_rts++;
      @(negedge clk);
    end
    checks++;
    if (n_inh !== 100 || n_rts !== 1) begin
      errors++;
      $display("FAIL f4_timing: inhibit=%0d rts=%0d cycles, required 100 and 1", n_inh, n_rts);
    end
    run_frame(11, 1'b0, 0, 0, got);
    wait_idle("f4");
    checks++;
    if (got !== 11'b1_0_11110100_0) begin
      errors++;
      $display("FAIL f4_frame: sampled %b, required %b", got, 11'b1_0_11110100_0);
    end
    checks++;
    if (done_cnt - d0 !== 1 || done_busy !== 1'b0 || done_oe !== 2'b00) begin
      errors++;
      $display("FAIL f4_done: pulses=%0d busy=%b oe=%b, required 1, 0, 00", done_cnt - d0, done_busy, done_oe);
    end
  endtask

  task automatic test_patterns();
    send_and_check(8'hFF, "ff", 0, 0);
    send_and_check(8'h00, "00", 0, 0);
    for (int i = 0; i < 4; i++) send_and_check(8'($urandom), "rand", 0, 0);
  endtask

  task automatic test_start_timeout();
    int t = 0, n = 0, e0 = err_cnt, d0 = done_cnt;
    start_tx(8'hF4);
    while (bus.ps2_clk_oe && t < 1000) begin
      @(negedge clk);
      t++;
    end
    while (!bus.tx_err && n < 20000) begin
      @(negedge clk);
      n++;
    end
    wait_idle("start_to");
    checks++;
    if (n !== 15000) begin
      errors++;
      $display("FAIL start_to_time: err after %0d cycles, required 15000", n);
    end
    checks++;
    if (err_cnt - e0 !== 1 || err_code !== 2'b01 || err_busy !== 1'b0 || err_oe !== 2'b00 || done_cnt != d0) begin
      errors++;
      $display("FAIL start_to_err: pulses=%0d code=%b busy=%b oe=%b done=%0d, required 1, 01, 0, 00, 0",
               err_cnt - e0, err_code, err_busy, err_oe, done_cnt - d0);
    end
  endtask

  task automatic test_bit_timeout();
    logic [10:0] got;
    int n = 0, e0 = err_cnt;
    start_tx(8'($urandom));
    run_frame(5, 1'b0, 0, 0, got);
    while (!bus.tx_err && n < 5000) begin
      @(negedge clk);
      n++;
    end
    wait_idle("bit_to");
    // the BFM spends 40 cycles after its last falling edge before returning
    checks++;
    if (n < 2000 - 40 || n > 2000 - 40 + 4) begin
      errors++;
      $display("FAIL bit_to_time: err %0d cycles after last edge, required 2000..2004", n + 40);
    end
    checks++;
    if (err_cnt - e0 !== 1 || err_code !== 2'b10) begin
      errors++;
      $display("FAIL bit_to_err: pulses=%0d code=%b, required 1 and 10", err_cnt - e0, err_code);
    end
  endtask

  task automatic test_nack();
    logic [10:0] got;
    int e0 = err_cnt, d0 = done_cnt;
    start_tx(8'hFF);
    run_frame(11, 1'b1, 0, 0, got);
    wait_idle("nack");
    checks++;
    if (err_cnt - e0 !== 1 || err_code !== 2'b11 || done_cnt - d0 !== 0) begin
      errors++;
      $display("FAIL nack: err=%0d code=%b done=%0d, required 1, 11, 0", err_cnt - e0, err_code, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] got;
    int e0 = err_cnt, d0 = done_cnt;
    start_tx(8'hA7);
    run_frame(4, 1'b0, 0, 0, got);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.tx_busy, bus.tx_done, bus.tx_err, bus.ps2_clk_oe, bus.ps2_data_oe} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid: busy/done/err/clk_oe/data_oe=%b, required 00000",
               {bus.tx_busy, bus.tx_done, bus.tx_err, bus.ps2_clk_oe, bus.ps2_data_oe});
    end
    repeat (50) @(negedge clk);
    checks++;
    if (err_cnt != e0 || done_cnt != d0) begin
      errors++;
      $display("FAIL reset_mid_pulses: err=%0d done=%0d, required 0 and 0", err_cnt - e0, done_cnt - d0);
    end
  endtask

  initial begin
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_send_f4();
    test_patterns();
    test_start_timeout();
    test_bit_timeout();
    test_nack();
    send_and_check(8'h3C, "ignore_start", 3, 0);
    send_and_check(8'($urandom), "glitch", 0, 4);
    test_reset_mid();
    send_and_check(8'($urandom), "b2b_a", 0, 0);
    send_and_check(8'($urandom), "b2b_b", 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
